// File: rtl/seq_alu.sv
// Multi-cycle ALU for the execute stage. Single-cycle ops complete at the
// accept edge; mul/divu/remu iterate one bit per clock behind a
// valid/ready handshake so the control unit can stall the pipeline.
module seq_alu #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             busy
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_SLL  = 4'b0011;
    localparam logic [3:0] OP_NE   = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_SRL  = 4'b0111;
    localparam logic [3:0] OP_SRA  = 4'b1000;
    localparam logic [3:0] OP_SLT  = 4'b1001;
    localparam logic [3:0] OP_SLTU = 4'b1010;
    localparam logic [3:0] OP_MUL  = 4'b1011;
    localparam logic [3:0] OP_DIVU = 4'b1100;
    localparam logic [3:0] OP_REMU = 4'b1101;

    localparam logic [SHW:0] CNT_LAST = (SHW + 1)'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nx;

    // Iteration registers. mul: x = multiplier, y = multiplicand, acc = product.
    // divu/remu: x = dividend shifting into quotient, y = divisor, acc = remainder.
    logic [WIDTH-1:0] x, y, acc;
    logic [WIDTH-1:0] x_nx, y_nx, acc_nx;
    logic [WIDTH-1:0] iter_res;
    logic [SHW:0]     cnt;
    logic [3:0]       op;
    logic             last;
    logic             is_iter;

    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             ovf_q;

    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic [WIDTH-1:0] sum, diff;
    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   rem_sh, trial;

    assign in_ready  = (state == IDLE);
    assign busy      = (state == BUSY);
    assign out_valid = (state == DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;

    assign last    = (cnt == CNT_LAST);
    assign is_iter = (alu_control == OP_MUL) || (alu_control == OP_DIVU) ||
                     (alu_control == OP_REMU);
    assign shamt   = b[SHW-1:0];
    assign sum     = a + b;
    assign diff    = a - b;

    // Single-cycle datapath, evaluated on the live operands at accept.
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned and infers a latch.
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        unique case (alu_control)
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_OR:   alu_res = a | b;
            OP_AND:  alu_res = a & b;
            OP_XOR:  alu_res = a ^ b;
            OP_SLL:  alu_res = a << shamt;
            OP_SRL:  alu_res = a >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(a) >>> shamt);
            OP_NE:   alu_res = {{(WIDTH-1){1'b0}}, (a != b)};
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            default: alu_res = '0;
        endcase
    end

    // One iteration of shift-add multiply or restoring division.
    always_comb begin
        rem_sh   = {acc, x[WIDTH-1]};
        trial    = rem_sh - {1'b0, y};
        x_nx     = x;
        y_nx     = y;
        acc_nx   = acc;
        iter_res = '0;
        if (op == OP_MUL) begin
            acc_nx   = acc + (x[0] ? y : '0);
            x_nx     = x >> 1;
            y_nx     = y << 1;
            iter_res = acc_nx;
        end else begin
            // A zero divisor always "fits", giving all-ones quotient and remainder = a.
            if (!trial[WIDTH]) begin
                acc_nx = trial[WIDTH-1:0];
                x_nx   = {x[WIDTH-2:0], 1'b1};
            end else begin
                acc_nx = rem_sh[WIDTH-1:0];
                x_nx   = {x[WIDTH-2:0], 1'b0};
            end
            iter_res = (op == OP_DIVU) ? x_nx : acc_nx;
        end
    end

    // State register.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (in_valid) state_nx = is_iter ? BUSY : DONE;
            BUSY:    if (last) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand latch, iteration registers and registered result flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x        <= '0;
            y        <= '0;
            acc      <= '0;
            cnt      <= '0;
            op       <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (is_iter) begin
                            op  <= alu_control;
                            acc <= '0;
                            cnt <= '0;
                            x   <= (alu_control == OP_MUL) ? b : a;
                            y   <= (alu_control == OP_MUL) ? a : b;
                        end else begin
                            result_q <= alu_res;
                            zero_q   <= (alu_res == '0);
                            ovf_q    <= alu_ovf;
                        end
                    end
                end
                BUSY: begin
                    x   <= x_nx;
                    y   <= y_nx;
                    acc <= acc_nx;
                    if (last) begin
                        cnt      <= '0;
                        result_q <= iter_res;
                        zero_q   <= (iter_res == '0);
                        ovf_q    <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
